// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one non-pipelined fpu_mul among NREQ requesters.
// Drives the multiplier's a/b/z stb-ack handshakes and returns each product to its issuer.
module fpu_mul_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_z,
  output logic [WIDTH-1:0]      mul_a,
  output logic                  mul_a_stb,
  input  logic                  mul_a_ack,
  output logic [WIDTH-1:0]      mul_b,
  output logic                  mul_b_stb,
  input  logic                  mul_b_ack,
  input  logic [WIDTH-1:0]      mul_z,
  input  logic                  mul_z_stb,
  output logic                  mul_z_ack,
  output logic                  busy,
  output logic [IdW-1:0]        grant_id,
  output logic [15:0]           ops_done
);

  typedef enum logic [2:0] {StIdle, StSendA, StSendB, StWaitZ, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [15:0]      ops_q, ops_d;
  logic             a_stb_q, a_stb_d;
  logic             b_stb_q, b_stb_d;
  logic             z_ack_q, z_ack_d;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [IdW-1:0]   win;
  logic [IdW-1:0]   cand;
  logic             found;
  logic             rsp_take;

  // Search ptr, ptr+1, ... mod NREQ; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign a_arr[g]     = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g]     = req_b[g*WIDTH +: WIDTH];
    // Gated by rst so no requester sees a grant while the block is held in reset.
    assign req_ready[g] = rst && (state_q == StIdle) && found && (win == IdW'(g));
    assign rsp_valid[g] = (state_q == StResp) && (gid_q == IdW'(g));
  end

  assign rsp_take = rsp_ready[gid_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    ops_d   = ops_q;
    a_stb_d = a_stb_q;
    b_stb_d = b_stb_q;
    z_ack_d = z_ack_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          a_d     = a_arr[win];
          b_d     = b_arr[win];
          gid_d   = win;
          ptr_d   = IdW'((32'(win) + 32'd1) % NREQ);
          a_stb_d = 1'b1;
          state_d = StSendA;
        end
      end
      StSendA: begin
        if (a_stb_q && mul_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = StSendB;
        end
      end
      StSendB: begin
        if (b_stb_q && mul_b_ack) begin
          b_stb_d = 1'b0;
          z_ack_d = 1'b1;
          state_d = StWaitZ;
        end
      end
      StWaitZ: begin
        if (mul_z_stb && z_ack_q) begin
          z_d     = mul_z;
          z_ack_d = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_take) begin
          ops_d   = ops_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ops_q   <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
      z_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      ops_q   <= ops_d;
      a_stb_q <= a_stb_d;
      b_stb_q <= b_stb_d;
      z_ack_q <= z_ack_d;
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_a_stb = a_stb_q;
  assign mul_b_stb = b_stb_q;
  assign mul_z_ack = z_ack_q;
  assign rsp_z     = z_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = gid_q;
  assign ops_done  = ops_q;

endmodule

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Round-robin arbiter that shares one non-pipelined `fpu_mul` instance among `NREQ` requesters. It accepts an operand pair from one requester at a time and drives the multiplier's three stb/ack handshakes: a, b, then z. It returns the product to the requester that issued it and counts completed operations. It sits between the requesting engines and the multiplier, and is the only master of the multiplier's handshake ports.

## Interface
- `WIDTH`, 32: float word width; must equal the `fpu_mul` build width.
- `NREQ`, 4: number of requesters, 2..8.
- `clk` in 1: single clock, shared with `fpu_mul`.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i has an operand pair pending.
- `req_ready` out NREQ: requester i's pair is accepted this cycle; one-hot or zero.
- `req_a` in NREQ*WIDTH: operand a of requester i in bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: operand b, same packing as `req_a`.
- `rsp_valid` out NREQ: product available for requester i; one-hot or zero.
- `rsp_ready` in NREQ: requester i accepts the product.
- `rsp_z` out WIDTH: product; shared bus, meaningful only while some `rsp_valid` bit is high.
- `mul_a`, `mul_a_stb` out WIDTH/1; `mul_a_ack` in 1: operand a handshake to the multiplier.
- `mul_b`, `mul_b_stb` out WIDTH/1; `mul_b_ack` in 1: operand b handshake to the multiplier.
- `mul_z` in WIDTH; `mul_z_stb` in 1; `mul_z_ack` out 1: result handshake from the multiplier.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out clog2(NREQ): current or most recent grantee.
- `ops_done` out 16: completed operations; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- **Round-robin pointer:** `ptr` resets to 0. The winner is the first i with `req_valid[i]` set, searching `ptr`, `ptr+1`, … mod NREQ.
- **IDLE:**
  - `req_ready[winner]` is high combinationally, only in IDLE and only while some `req_valid` bit is set.
  - On `req_valid & req_ready`, latch `req_a`/`req_b` of the winner into internal registers.
  - In the same edge: set `grant_id` to the winner, set `ptr` to (winner+1) mod NREQ, go to SEND_A.
- **SEND_A:**
  - `mul_a_stb` is registered: high from the first SEND_A cycle. `mul_a` holds the latched a.
  - On an edge with `mul_a_stb && mul_a_ack`, go to SEND_B; `mul_a_stb` is low the following cycle.
- **SEND_B:** same rules as SEND_A with `mul_b`/`mul_b_stb`/`mul_b_ack`, then go to WAIT_Z.
- **WAIT_Z:**
  - `mul_z_ack` is registered high.
  - On `mul_z_stb && mul_z_ack`, capture `mul_z` into the result register, drop `mul_z_ack` next cycle, go to RESP.
- **RESP:**
  - `rsp_valid[grant_id]` is high and `rsp_z` holds the captured product.
  - On `rsp_ready[grant_id]`, increment `ops_done` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- **Stability:** a strobe, once raised, holds with stable data until its handshake completes. Requests arriving outside IDLE wait; they are never dropped and never see `req_ready`.
- **No data modification:** `rsp_z` equals `mul_z` bit-exactly, including NaN/inf/zero encodings.

## Timing
- **Reset values:** `req_ready`, `rsp_valid`, `mul_*_stb`, `mul_z_ack`, `busy` = 0. `mul_a`, `mul_b`, `rsp_z`, `grant_id`, `ops_done`, `ptr` = 0. State = IDLE.
- **Reset mid-operation:** asserting `rst` in any state aborts immediately. The in-flight result is lost and no `rsp_valid` is issued. The top level resets `fpu_mul` in the same cycles (its `rst` driven high while ours is low) so both restart aligned.
- **Arbiter overhead per operation:**
  - 1 cycle from acceptance to `mul_a_stb`.
  - 1 cycle from the a transfer to `mul_b_stb`.
  - 1 cycle from the z transfer to `rsp_valid`.
  - Fastest RESP→IDLE→next acceptance: 1 cycle in IDLE.
- **Multiplier pacing:** the multiplier raises ack one cycle after it enters its get state. The first a transfer therefore occurs at the earliest on the second SEND_A cycle.
- **Simultaneous events:** if all `req_valid` bits are set continuously, grants rotate 0,1,2,3,0,… A requester that drops `req_valid` before acceptance loses nothing: there is no stored grant.
- **Back-pressure:** RESP lasts indefinitely while `rsp_ready[grant_id]` is low. No new request is accepted until the response is taken.

## Test plan
- **Single multiply:** requester 2 sends a=0x40000000, b=0x40400000 → `rsp_valid[2]`, `rsp_z`=0x40C00000, `grant_id`=2, `ops_done`=1.
- **Rotation:** all four requesters are valid from reset with a=0x3FC00000, b=0x3FC00000 → grants in order 0,1,2,3, each returning 0x40100000. `req_ready` stays one-hot and `rsp_valid` is never set for two requesters at once.
- **Response back-pressure:** hold `rsp_ready[1]` low for 20 cycles → `rsp_valid[1]` and `rsp_z` stay stable, other requesters never see `req_ready`, and `ops_done` increments only at the accepting edge.
- **NaN pass-through:** a=0x7FC00000, b=0x3F800000 → `rsp_z`=0xFFC00000, unchanged from `mul_z`.
- **Reset during WAIT_Z:** pulse `rst` low mid-operation → all outputs return to reset values asynchronously and no `rsp_valid` is seen. The next request after reset completes correctly with `grant_id` starting from requester 0.
- **Counter wrap:** force 65536 operations (or preload `ops_done` in simulation to 0xFFFF) → `ops_done` wraps to 0x0000.
